// File: rtl/mesh_scan_pkg.sv
// Shared types and helpers for the mesh scan sequencer.
// ST_WAIT exists only when MESH_SCAN_CONT_EN is defined.
package mesh_scan_pkg;

    localparam int LC_D       = 64;
    localparam int PC_D       = 32;
    localparam int GC_D       = 4;
    localparam int SETTLE_W_D = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
`ifdef MESH_SCAN_CONT_EN
        ,
        ST_WAIT   = 3'd7
`endif
    } state_e;

    // A programmed count of zero still has to spend one cycle in the timed state.
    function automatic logic [31:0] clamp_min1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/mesh_scan_cmp.sv
// Reduces a captured tap vector against the expected level into per-group error flags.
module mesh_scan_cmp
#(
    parameter int PC = 32,
    parameter int GC = 4
) (
    input  logic [PC-1:0] cap_i,
    input  logic          exp_i,
    input  logic          en_i,
    output logic [GC-1:0] grp_err_o
);

    localparam int GW = PC / GC;

    always_comb begin
        grp_err_o = '0;
        if (en_i) begin
            for (int k = 0; k < GC; k++) begin
                for (int j = 0; j < GW; j++) begin
                    if (cap_i[k*GW + j] != exp_i) begin
                        grp_err_o[k] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mesh_scan_ctrl.sv
// Mesh-line scan sequencer: drives each enabled line high then low, samples its taps, logs sticky faults.
// Continuous re-scan with an idle gap is compiled in when MESH_SCAN_CONT_EN is defined.
//   state  | meaning
//   IDLE   | waiting for start
//   SEL    | decide whether line idx is enabled
//   SETTLE | drive pattern applied, counting settle cycles
//   SAMPLE | capture the selected line's taps
//   CHECK  | compare capture, update sticky status
//   NEXT   | advance to the next line or finish
//   DONE   | end of pass
//   WAIT   | gap between passes (continuous mode only)
module mesh_scan_ctrl
    import mesh_scan_pkg::*;
#(
    parameter int LC       = LC_D,
    parameter int PC       = PC_D,
    parameter int GC       = GC_D,
    parameter int SETTLE_W = SETTLE_W_D,
    parameter int IDX_W    = $clog2(LC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmsatpg,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cont,
    input  logic [SETTLE_W-1:0]  cfg_settle,
    input  logic [LC-1:0]        cfg_lmask,
    input  logic [SETTLE_W-1:0]  cfg_interval,
    input  logic [LC*PC-1:0]     apt_i,
    input  logic [LC*GC-1:0]     sr_clr,
    output logic [LC-1:0]        mldrv_o,
    output logic [LC-1:0]        mlie_o,
    output logic                 busy,
    output logic                 done,
    output logic                 err_pulse,
    output logic [IDX_W-1:0]     err_line,
    output logic [LC*GC-1:0]     sr_o,
    output logic                 irq
);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  phase_q, phase_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic [PC-1:0]         cap_q;
    logic [LC*GC-1:0]      sr_q, sr_d, sr_set;
    logic                  irq_q, done_q, err_pulse_q, busy_q;
    logic [IDX_W-1:0]      err_line_q;
    logic [LC-1:0]         drv_q, drv_d, ie_q, ie_d;
    logic [GC-1:0]         grp_err;
    logic                  mis_any;
    logic                  act_d;
    logic [SETTLE_W-1:0]   settle_eff;

    assign settle_eff = SETTLE_W'(clamp_min1(32'(cfg_settle)));

`ifdef MESH_SCAN_CONT_EN
    logic [SETTLE_W-1:0]   wcnt_q, wcnt_d;
    logic [SETTLE_W-1:0]   interval_eff;

    assign interval_eff = SETTLE_W'(clamp_min1(32'(cfg_interval)));
`else
    logic unused_cont_cfg;

    assign unused_cont_cfg = ^{cont, cfg_interval};
`endif

    mesh_scan_cmp #(
        .PC (PC),
        .GC (GC)
    ) u_cmp (
        .cap_i     (cap_q),
        .exp_i     (~phase_q),
        .en_i      (state_q == ST_CHECK),
        .grp_err_o (grp_err)
    );

    assign mis_any = |grp_err;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
`ifdef MESH_SCAN_CONT_EN
        wcnt_d  = wcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    phase_d = 1'b0;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (cfg_lmask[idx_q]) begin
                    cnt_d   = settle_eff;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - SETTLE_W'(1);
                if (cnt_q <= SETTLE_W'(1)) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    cnt_d   = settle_eff;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                phase_d = 1'b0;
                if (idx_q == IDX_W'(LC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SEL;
                end
            end
            ST_DONE: begin
`ifdef MESH_SCAN_CONT_EN
                if (cont) begin
                    wcnt_d  = interval_eff;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef MESH_SCAN_CONT_EN
            ST_WAIT: begin
                if (!cont) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q - SETTLE_W'(1);
                    if (wcnt_q <= SETTLE_W'(1)) begin
                        idx_d   = '0;
                        phase_d = 1'b0;
                        state_d = ST_SEL;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort || cmsatpg) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
        end
    end

    // Drive pattern is registered from next-state values so pins are glitch-free and track the state.
    always_comb begin
        act_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) || (state_d == ST_CHECK);
        drv_d = '0;
        ie_d  = '0;
        if (act_d) begin
            drv_d        = cfg_lmask & {LC{phase_d}};
            drv_d[idx_d] = ~phase_d;
            ie_d[idx_d]  = 1'b1;
        end
    end

    always_comb begin
        sr_set                  = '0;
        sr_set[idx_q*GC +: GC]  = grp_err;
        sr_d                    = (sr_q & ~sr_clr) | sr_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            cap_q       <= '0;
            sr_q        <= '0;
            irq_q       <= 1'b0;
            done_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_line_q  <= '0;
            busy_q      <= 1'b0;
            drv_q       <= '0;
            ie_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            if (state_q == ST_SAMPLE) begin
                cap_q <= apt_i[idx_q*PC +: PC];
            end
            sr_q        <= sr_d;
            irq_q       <= |sr_q;
            done_q      <= (state_q == ST_DONE) && !abort && !cmsatpg;
            err_pulse_q <= mis_any;
            if (mis_any) begin
                err_line_q <= idx_q;
            end
            busy_q      <= (state_d != ST_IDLE);
            drv_q       <= drv_d;
            ie_q        <= ie_d;
        end
    end

`ifdef MESH_SCAN_CONT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`endif

    assign mldrv_o   = drv_q;
    assign mlie_o    = ie_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_pulse = err_pulse_q;
    assign err_line  = err_line_q;
    assign sr_o      = sr_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_mesh_scan_ctrl.sv
// Self-checking bench for mesh_scan_ctrl: table of full scan passes plus abort/ATPG/reset/continuous sequences.
module tb_mesh_scan_ctrl;

    localparam int LC = 64;
    localparam int PC = 32;
    localparam int GC = 4;
    localparam int SW = 16;
    localparam int IW = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmsatpg, start, abort, cont;
    logic [SW-1:0]        cfg_settle, cfg_interval;
    logic [LC-1:0]        cfg_lmask;
    logic [LC*PC-1:0]     apt_i;
    logic [LC*GC-1:0]     sr_clr;
    logic [LC-1:0]        mldrv_o, mlie_o;
    logic                 busy, done, err_pulse, irq;
    logic [IW-1:0]        err_line;
    logic [LC*GC-1:0]     sr_o;

    bit                   stuck_en;
    int                   stuck_bit;
    bit                   stuck_val;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mesh_scan_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cmsatpg      (cmsatpg),
        .start        (start),
        .abort        (abort),
        .cont         (cont),
        .cfg_settle   (cfg_settle),
        .cfg_lmask    (cfg_lmask),
        .cfg_interval (cfg_interval),
        .apt_i        (apt_i),
        .sr_clr       (sr_clr),
        .mldrv_o      (mldrv_o),
        .mlie_o       (mlie_o),
        .busy         (busy),
        .done         (done),
        .err_pulse    (err_pulse),
        .err_line     (err_line),
        .sr_o         (sr_o),
        .irq          (irq)
    );

    // Tap inputs loop back each line's drive level, with one optional stuck tap.
    always_comb begin
        for (int i = 0; i < LC; i++) begin
            for (int j = 0; j < PC; j++) begin
                apt_i[i*PC + j] = mldrv_o[i];
            end
        end
        if (stuck_en) apt_i[stuck_bit] = stuck_val;
    end

    typedef struct {
        logic [63:0] lmask;
        int          settle;
        int          mid;
        bit          sen;
        int          sbit;
        bit          sval;
        int          cyc;
        int          nerr;
        int          line;
        int          srbit;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clr_sr();
        sr_clr = '1;
        tick();
        sr_clr = '0;
        tick();
        tick();
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        while (cyc < bound) begin
            tick();
            cyc++;
            if (done) break;
        end
    endtask

    task automatic run_pass(input int mid, output int cyc, output int nerr, output int last_line,
                            output logic [63:0] ie_seen, output int drv_bad, output int ndone,
                            output int irq_bad);
        logic [LC*GC-1:0] prev_sr;
        logic [LC-1:0]    expd;
        logic             d;
        nerr = 0; last_line = -1; ie_seen = '0; drv_bad = 0; ndone = 0; irq_bad = 0;
        prev_sr = sr_o;
        start_pass();
        cyc = 0;
        while (cyc < 2000) begin
            if (irq !== (|prev_sr)) irq_bad++;
            prev_sr = sr_o;
            tick();
            cyc++;
            start = (cyc == mid);
            if (err_pulse) begin
                nerr++;
                last_line = int'(err_line);
            end
            ie_seen |= mlie_o;
            if (mlie_o != '0) begin
                d    = |(mldrv_o & mlie_o);
                expd = d ? mlie_o : (cfg_lmask & ~mlie_o);
                if (mldrv_o !== expd) drv_bad++;
            end else if (mldrv_o != '0) begin
                drv_bad++;
            end
            if (done) begin
                ndone++;
                break;
            end
        end
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) ndone++;
        end
    endtask

    initial begin
        int               cyc, nerr, line, drv_bad, ndone, irq_bad;
        logic [63:0]      ie_seen;
        logic [255:0]     exp_sr;

        vt[0] = '{64'h0000_0000_0000_0020, 4, -1, 1'b0, 0,    1'b0, 141, 0, 0,  -1};
        vt[1] = '{64'h0000_0000_0000_0020, 4, -1, 1'b1, 169,  1'b0, 141, 1, 5,  21};
        vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 200, 1'b0, 0,   1'b0, 513, 0, 0,  -1};
        vt[3] = '{64'h0000_0000_0000_0000, 7, -1, 1'b0, 0,    1'b0, 129, 0, 0,  -1};
        vt[4] = '{64'h8000_0000_0000_0001, 2, -1, 1'b1, 2047, 1'b0, 145, 1, 63, 255};
        vt[5] = '{64'h0000_0000_0000_0400, 1, -1, 1'b0, 0,    1'b0, 135, 0, 0,  -1};
        vt[6] = '{64'h0000_0000_0000_0004, 3, -1, 1'b1, 80,   1'b1, 139, 1, 2,  10};
        vt[7] = '{64'h0000_0000_0000_0020, 4, -1, 1'b1, 0,    1'b0, 141, 0, 0,  -1};

        reset = 1'b1; cmsatpg = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
        cfg_settle = '0; cfg_interval = '0; cfg_lmask = '0; sr_clr = '0;
        stuck_en = 1'b0; stuck_bit = 0; stuck_val = 1'b0;
        repeat (3) tick();
        chk("rst_drv", mldrv_o, 0);
        chk("rst_ie", mlie_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sr", sr_o, 0);
        chk("rst_irq", irq, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            cfg_lmask  = vt[v].lmask;
            cfg_settle = SW'(vt[v].settle);
            stuck_en   = vt[v].sen;
            stuck_bit  = vt[v].sbit;
            stuck_val  = vt[v].sval;
            clr_sr();
            run_pass(vt[v].mid, cyc, nerr, line, ie_seen, drv_bad, ndone, irq_bad);
            exp_sr = '0;
            if (vt[v].srbit >= 0) exp_sr[vt[v].srbit] = 1'b1;
            $display("vector %0d: done after %0d cycles", v, cyc);
            chk("pass_cycles", cyc, vt[v].cyc);
            chk("err_count", nerr, vt[v].nerr);
            if (vt[v].nerr > 0) chk("err_line", line, vt[v].line);
            chk("ie_lines", ie_seen, vt[v].lmask);
            chk("drive_pattern_bad", drv_bad, 0);
            chk("done_count", ndone, 1);
            chk("irq_lag_bad", irq_bad, 0);
            chk("sr_final", sr_o, exp_sr);
            chk("irq_final", irq, |exp_sr);
            chk("busy_after", busy, 0);
        end

        // irq drop after clearing a single status bit
        cfg_lmask = 64'h20; cfg_settle = 4; stuck_en = 1'b1; stuck_bit = 169; stuck_val = 1'b0;
        clr_sr();
        start_pass();
        wait_done(400, cyc);
        chk("stuck_sr21", sr_o[21], 1);
        chk("stuck_irq", irq, 1);
        sr_clr = '0; sr_clr[21] = 1'b1;
        tick();
        sr_clr = '0;
        chk("clr_sr21", sr_o, 0);
        chk("clr_irq_lag", irq, 1);
        tick();
        chk("clr_irq_drop", irq, 0);

        // set wins over a simultaneous clear
        sr_clr[21] = 1'b1;
        start_pass();
        cyc = 0;
        while (cyc < 300 && !err_pulse) begin
            tick();
            cyc++;
        end
        chk("setwins_pulse", err_pulse, 1);
        chk("setwins_sr21", sr_o[21], 1);
        tick();
        chk("clr_after_set", sr_o[21], 0);
        wait_done(400, cyc);
        chk("setwins_done", done, 1);
        sr_clr = '0;
        tick();

        // abort during SETTLE of line 3, earlier fault on line 0 kept
        cfg_lmask = '1; cfg_settle = 4; stuck_en = 1'b1; stuck_bit = 0; stuck_val = 1'b0;
        clr_sr();
        start_pass();
        repeat (44) tick();
        chk("pre_abort_ie", mlie_o, 64'h8);
        chk("pre_abort_sr", sr_o, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_drv", mldrv_o, 0);
        chk("abort_ie", mlie_o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sr_kept", sr_o, 1);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // ATPG mode mid-pass behaves like abort
        clr_sr();
        start_pass();
        repeat (44) tick();
        chk("pre_atpg_ie", mlie_o, 64'h8);
        cmsatpg = 1'b1;
        tick();
        chk("atpg_drv", mldrv_o, 0);
        chk("atpg_ie", mlie_o, 0);
        chk("atpg_busy", busy, 0);
        chk("atpg_sr_kept", sr_o, 1);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        cmsatpg = 1'b0;
        chk("atpg_no_done", ndone, 0);

        // asynchronous reset mid-pass
        start_pass();
        repeat (20) tick();
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_sr", sr_o, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_drv", mldrv_o, 0);
        chk("arst_ie", mlie_o, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_errp", err_pulse, 0);
        chk("arst_errl", err_line, 0);
        chk("arst_sr", sr_o, 0);
        chk("arst_irq", irq, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        stuck_en = 1'b0;
        cfg_lmask = 64'h1; cfg_settle = 1; cfg_interval = 10;
`ifdef MESH_SCAN_CONT_EN
        cont = 1'b1;
        start_pass();
        wait_done(400, cyc);
        chk("cont_first_done", cyc, 135);
        chk("cont_busy_wait", busy, 1);
        cyc = 0;
        while (cyc < 100 && mlie_o == '0) begin
            tick();
            cyc++;
        end
        chk("cont_restart_gap", cyc, 11);
        wait_done(400, cyc);
        chk("cont_second_done", done, 1);
        cont = 1'b0;
        tick();
        chk("cont_drop_idle", busy, 0);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done || mlie_o != '0) ndone++;
        end
        chk("cont_stopped", ndone, 0);
`else
        cont = 1'b1;
        start_pass();
        wait_done(400, cyc);
        chk("nocont_done", cyc, 135);
        chk("nocont_idle", busy, 0);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done || busy || mlie_o != '0) ndone++;
        end
        chk("nocont_no_rescan", ndone, 0);
        cont = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mesh_scan_ctrl.md
Name: mesh_scan_ctrl

Overview:
- Sequencer for the active-shield mesh lines: walks every enabled line, drives it high then low, waits a programmable settle time, samples that line's tap points and compares them with the driven level.
- Sits between the mesh SFR/APB front end and the mesh line drivers/input buffers. Replaces static software-driven DRV/IE patterns with an autonomous hardware scan.
- Accumulates sticky per-line, per-tap-group fault status and raises an interrupt.

Parameters:
- LC, 64, number of mesh lines.
- PC, 32, tap points per line.
- GC, 4, tap groups per line; PC must be a multiple of GC; GW = PC/GC taps per group.
- SETTLE_W, 16, width of the settle-time counter.
- IDX_W, $clog2(LC), width of the line index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmsatpg  in  1  scan/ATPG mode; forces IDLE and zeroes all mesh outputs.
- start  in  1  single-cycle request to begin one scan pass.
- abort  in  1  stop the current pass.
- cont  in  1  continuous-mode enable (used only with MESH_SCAN_CONT_EN).
- cfg_settle  in  SETTLE_W  settle cycles per phase; 0 is treated as 1.
- cfg_lmask  in  LC  line enable mask.
- cfg_interval  in  SETTLE_W  idle gap between passes in continuous mode.
- apt_i  in  LC*PC  tap-point inputs; line i occupies bits [i*PC +: PC].
- sr_clr  in  LC*GC  write-1-to-clear for the status bits.
- mldrv_o  out  LC  line drive levels.
- mlie_o  out  LC  tap input-enable, one-hot on the selected line.
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- err_pulse  out  1  one-cycle pulse for each CHECK that finds a mismatch.
- err_line  out  IDX_W  line index of the last mismatch.
- sr_o  out  LC*GC  sticky fault status; bit i*GC+k covers line i, group k.
- irq  out  1  registered OR of sr_o.

Behaviour:
- Reset values: every output 0, state IDLE, idx 0, phase 0, internal counters 0.
- FSM states: IDLE, SEL, SETTLE, SAMPLE, CHECK, NEXT, DONE.
- IDLE: start=1 sets idx=0 and phase=0 and moves to SEL. busy is high in every state except IDLE. start is ignored while busy.
- SEL:
  - If cfg_lmask[idx]=1: load cnt = max(cfg_settle,1), go to SETTLE.
  - Otherwise go to NEXT.
- Drive rules while line idx is selected:
  - mldrv_o[idx] = ~phase (phase 0 drives 1, phase 1 drives 0).
  - All other enabled lines drive phase, i.e. the opposite level, so bridging faults between lines are exposed.
  - mlie_o[idx] = 1; every other mlie_o bit is 0.
  - Outside SETTLE/SAMPLE/CHECK, mldrv_o = 0 and mlie_o = 0.
- SETTLE: cnt decrements each cycle; on the cycle cnt==1, go to SAMPLE.
- SAMPLE: register apt_i[idx*PC +: PC] into a PC-bit capture register.
- CHECK:
  - mis[j] = capture[j] != ~phase.
  - grp_err[k] = OR of mis over group k.
  - sr bit [idx*GC+k] is set for each grp_err[k].
  - If any mismatch: err_pulse=1 and err_line=idx.
  - Then: if phase=0, set phase=1, reload cnt, go to SETTLE; otherwise go to NEXT.
- NEXT: phase=0. If idx==LC-1 go to DONE; otherwise idx+1 and go to SEL.
- DONE: done=1 for one cycle, then go to IDLE.
- Timing: an enabled line costs 2*N+6 cycles, a disabled line costs 2 cycles, where N is the effective settle count.
- Boundaries:
  - cfg_lmask all zero: the pass completes with no drive activity.
  - Config is sampled live; software must hold it stable while busy.
  - sr_clr and a set on the same bit in the same cycle: set wins.
  - irq lags sr_o by one cycle.
- abort, or cmsatpg=1, in any state: next state is IDLE, no done pulse, mldrv_o and mlie_o are 0 from the next cycle. sr_o is retained.
- reset mid-pass: immediate return to reset values, including sr_o.

Optional Feature:
- Macro: MESH_SCAN_CONT_EN.
- When defined and cont=1:
  - DONE goes to a WAIT state instead of IDLE; busy stays high.
  - WAIT counts max(cfg_interval,1) cycles, then restarts at SEL with idx=0.
  - Dropping cont during WAIT returns to IDLE on the next cycle.
  - abort and cmsatpg also exit WAIT.
- When not defined: the cont and cfg_interval ports exist but are ignored, and the WAIT state is absent.

Decomposition:
- Package mesh_scan_pkg holds:
  - the state enum typedef;
  - defaults LC_D=64, PC_D=32, GC_D=4;
  - a function for settle clamping, max(x,1).
- One sub-module, mesh_scan_cmp: combinational group reduction from the PC-bit capture, expected level and enable to a GC-bit grp_err.

Test Plan:
- Lmask=1<<5, settle=4, apt_i looped to mldrv_o on every tap → done 141 cycles after start accepted; sr_o=0; irq=0; mlie_o[5] is the only ie bit seen high.
- Same setup with apt_i[5*32+9] stuck 0 → err_pulse once in phase 0, err_line=5, sr_o bit 21 set, irq high one cycle later. sr_clr bit 21 → bit cleared, irq drops.
- Lmask all ones, settle=0 → each line takes 8 cycles, done at cycle 513. start pulsed mid-pass → ignored, exactly one done.
- abort during SETTLE of line 3 → mldrv_o=0, mlie_o=0 and busy=0 next cycle; no done; previously set sr bits kept.
- cmsatpg=1 mid-pass → same response as abort. Async reset mid-pass → all outputs 0 immediately, including sr_o.
- MESH_SCAN_CONT_EN, cont=1, interval=10 → second pass begins 10 cycles after the first done. cont=0 during WAIT → IDLE next cycle.
